// File: rtl/reset_sequencer.sv
// Reset generator: async-assert/sync-release of clr, then staggered per-channel release.
// Optional software re-sequence request enabled by defining RST_SEQ_SW_REQ_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                sw_rst_req,
    output logic [CHANNELS-1:0] sys_rst,
    output logic                rst_done
);
    localparam int MAX_CYC = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(CHANNELS) + 1;

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_rst;
    logic                   sw_req;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [CHANNELS-1:0]    sys_rst_reg, sys_rst_next;
    logic                   rst_done_reg, rst_done_next;
    logic                   release_en;
    logic                   set_all;

`ifdef RST_SEQ_SW_REQ_EN
    assign sw_req = sw_rst_req;
`else
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req;
    assign sw_req            = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        rst_done_next = rst_done_reg;
        release_en    = 1'b0;
        set_all       = 1'b0;
        case (state_reg)
            S_HOLD: begin
                if (sync_rst) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                    release_en = 1'b1;
                    cnt_next   = '0;
                    if (CHANNELS == 1) begin
                        state_next    = S_DONE;
                        rst_done_next = 1'b1;
                    end else begin
                        state_next = S_RELEASE;
                        idx_next   = IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (cnt_reg == CNT_W'(STAGGER - 1)) begin
                    release_en = 1'b1;
                    cnt_next   = '0;
                    idx_next   = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(CHANNELS - 1)) begin
                        state_next    = S_DONE;
                        rst_done_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
        // A software request overrides any release scheduled for the same edge.
        if (sw_req) begin
            state_next    = S_HOLD;
            cnt_next      = '0;
            idx_next      = '0;
            rst_done_next = 1'b0;
            release_en    = 1'b0;
            set_all       = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign sys_rst_next[gi] = set_all |
                (sys_rst_reg[gi] & ~(release_en && (idx_reg == IDX_W'(gi))));
        end
    endgenerate

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg    <= S_HOLD;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            sys_rst_reg  <= '1;
            rst_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            sys_rst_reg  <= sys_rst_next;
            rst_done_reg <= rst_done_next;
        end
    end

    assign sys_rst  = sys_rst_reg;
    assign rst_done = rst_done_reg;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator: asynchronously asserts and synchronously releases the reset from `clr`, then releases `CHANNELS` downstream reset outputs one at a time in a fixed order. Optionally accepts a software reset request that re-runs the sequence without toggling `clr`. It sits at the top of each clock domain and drives the reset of every subsystem in that domain, in dependency order: channel 0 first, channel `CHANNELS-1` last.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on the `clr` release path; legal range ≥ 2.
- `CHANNELS`, default 4: number of sequenced reset outputs; legal range ≥ 1.
- `HOLD_CYCLES`, default 16: cycles reset stays asserted after the synchroniser releases, before channel 0 releases; legal range ≥ 1.
- `STAGGER`, default 8: cycles between successive channel releases; legal range ≥ 1.

Ports:
- `clk`  input  1: the single clock.
- `clr`  input  1: asynchronous, active-high reset.
- `sw_rst_req`  input  1: synchronous software reset request, sampled on `clk`; active only with `RST_SEQ_SW_REQ_EN`.
- `sys_rst`  output  `CHANNELS`: active-high reset, one bit per channel; driven directly from flops.
- `rst_done`  output  1: high once every channel is released; driven from a flop.

## Operation
- **`clr` high.** Asynchronously, with no clock needed:
  - all synchroniser flops go to 1;
  - `sys_rst` = all ones;
  - `rst_done` = 0;
  - state = HOLD, counter = 0, channel index = 0.
- **Synchroniser.** A `SYNC_STAGES`-deep chain shifts in 0 while `clr` is low. Its output `sync_rst` gates the FSM.
- **HOLD.**
  - While `sync_rst` = 1, the counter is held at 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches `HOLD_CYCLES-1`, that edge clears `sys_rst[0]`, resets the counter and moves the FSM to RELEASE with channel index = 1.
- **RELEASE.**
  - The counter increments each cycle.
  - When it reaches `STAGGER-1`, that edge clears `sys_rst[index]`, increments the index and resets the counter.
  - The edge that clears `sys_rst[CHANNELS-1]` also sets `rst_done` = 1 and moves the FSM to DONE.
  - If `CHANNELS` = 1, RELEASE is skipped: HOLD goes straight to DONE and sets `rst_done` on the same edge as `sys_rst[0]` clears.
- **DONE.** All outputs stay static until `clr` or a software request.
- **Released bits stay released.** A bit, once cleared, is only re-set by `clr` or a software request.
- **Register widths.**
  - Counter: `$clog2(max(HOLD_CYCLES, STAGGER))+1` bits.
  - Channel index: `$clog2(CHANNELS)+1` bits.
  - No wrap-around is possible within legal parameters.
- **Software request** (only with the macro). `sw_rst_req` = 1 sampled at an edge, in any state:
  - `sys_rst` = all ones and `rst_done` = 0 at that same edge;
  - state = HOLD, counter = 0, index = 0;
  - the synchroniser is not touched.
  - Holding `sw_rst_req` high keeps the counter at 0, which extends the hold.
  - `sw_rst_req` takes priority over a release that would occur on the same edge.
- **`clr` mid-sequence.** Immediate asynchronous return to the reset values above. The full sequence restarts from the synchroniser.

## Timing
- Edge numbering: edge 1 is the first rising edge with `clr` low, meeting recovery time.
- `sync_rst` falls at edge `SYNC_STAGES`.
- `sys_rst[0]` falls at edge `SYNC_STAGES+HOLD_CYCLES`.
- `sys_rst[k]` falls at edge `SYNC_STAGES+HOLD_CYCLES+k*STAGGER`.
- `rst_done` rises on the same edge as `sys_rst[CHANNELS-1]` falls.
- Software request sampled at edge 0 (with `sw_rst_req` then low):
  - `sys_rst[0]` falls at edge `HOLD_CYCLES`;
  - `sys_rst[k]` falls at edge `HOLD_CYCLES+k*STAGGER`.
- Assertion of `clr` has zero-cycle latency (asynchronous). Every deassertion is synchronous to `clk`.

## Configuration
- Macro: `RST_SEQ_SW_REQ_EN`.
- **Defined:** the software request behaves as described above.
- **Undefined:**
  - the `sw_rst_req` port remains but is ignored, with no logic fan-in;
  - the sequence runs only from `clr`;
  - DONE is terminal until `clr`.

## Test plan
- **Power-on, defaults** (2/4/16/8): drop `clr` before edge 1 -> `sys_rst` falls 4'b1111 → 1110 @18 → 1100 @26 → 1000 @34 → 0000 @42; `rst_done` rises @42.
- **Async assert:** raise `clr` mid-cycle while in DONE, with no clock edge -> `sys_rst` = 4'b1111 and `rst_done` = 0 immediately; lower `clr` -> the 18/26/34/42 sequence repeats.
- **Reset mid-operation:** pulse `clr` at edge 30 (state 4'b1100) -> all ones immediately; sequence restarts from edge 1 after release.
- **Software request** (macro defined): pulse `sw_rst_req` for 1 cycle at edge 100 in DONE -> 4'b1111 @100; releases @116, 124, 132, 140; `rst_done` @140.
- **Held request / same-edge priority:** hold `sw_rst_req` for edges 100–109 -> channel 0 releases @125. Separately, pulse `sw_rst_req` on the edge a channel would release -> that channel stays asserted and HOLD restarts.
- **Edge parameters:** `CHANNELS`=1, `HOLD_CYCLES`=1, `SYNC_STAGES`=3 -> `sys_rst` and `rst_done` both change @4. Macro undefined: `sw_rst_req` toggling has no effect on any output.
